// File: rtl/lsu_pkg.sv
// Shared LSU types: FSM states, access-size encoding and byte-enable lookup for the load aligner.
// The two-beat path is only used when LOAD_ALIGNER_MISALIGNED_EN is defined.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ_LO  = 3'd1,
        WAIT_LO = 3'd2,
        REQ_HI  = 3'd3,
        WAIT_HI = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        SZ_WORD = 2'd0,
        SZ_HALF = 2'd1,
        SZ_BYTE = 2'd2
    } size_t;

    // {lb,lh}: 10 byte, 01 half, 00/11 word
    function automatic size_t decode_size(input logic lb, input logic lh);
        case ({lb, lh})
            2'b10:   return SZ_BYTE;
            2'b01:   return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

    function automatic logic is_misaligned(input size_t sz, input logic [1:0] off);
        case (sz)
            SZ_WORD: return off != 2'd0;
            SZ_HALF: return off == 2'd3;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] be_lo(input size_t sz, input logic [1:0] off);
        case (sz)
            SZ_WORD: return 4'b1111 << off;
            SZ_HALF: return (off == 2'd3) ? 4'b1000 : (4'b0011 << off);
            default: return 4'b0001 << off;
        endcase
    endfunction

    // Bytes that spill into the next word for a misaligned access
    function automatic logic [3:0] be_hi(input size_t sz, input logic [1:0] off);
        logic [3:0] be;
        be = 4'b0000;
        case (sz)
            SZ_WORD: begin
                case (off)
                    2'd1:    be = 4'b0001;
                    2'd2:    be = 4'b0011;
                    2'd3:    be = 4'b0111;
                    default: be = 4'b0000;
                endcase
            end
            SZ_HALF: be = (off == 2'd3) ? 4'b0001 : 4'b0000;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/load_extender.sv
// Combinational recombine/shift/extend of one or two bus words into the 32-bit load result.
// hi must be zero for single-beat accesses.
module load_extender
    import lsu_pkg::*;
(
    input  logic [31:0] lo,
    input  logic [31:0] hi,
    input  logic [1:0]  off,
    input  size_t       size,
    input  logic        lu,
    output logic [31:0] result
);

    logic [4:0]  sh;
    logic [5:0]  sh_hi;
    logic [31:0] w;

    assign sh    = {off, 3'b000};
    assign sh_hi = 6'd32 - {1'b0, sh};

    // The hi term is forced to zero at offset 0 where the shift would be a full 32
    always_comb begin
        w = lo >> sh;
        if (off != 2'd0)
            w = w | (hi << sh_hi);
    end

    always_comb begin
        result = w;
        case (size)
            SZ_BYTE: result = lu ? {24'd0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
            SZ_HALF: result = lu ? {16'd0, w[15:0]} : {{16{w[15]}}, w[15:0]};
            default: result = w;
        endcase
    end

endmodule

// File: rtl/load_aligner.sv
// Load aligner: issues word-aligned reads, optionally splits misaligned loads into two beats.
// Define LOAD_ALIGNER_MISALIGNED_EN for two-beat misaligned loads; otherwise they error out.
module load_aligner
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_req_i,
    input  logic              lb_i,
    input  logic              lh_i,
    input  logic              lu_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              data_req_o,
    output logic [ADDR_W-1:0] data_addr_o,
    output logic [3:0]        data_be_o,
    input  logic              data_gnt_i,
    input  logic              data_rvalid_i,
    input  logic [31:0]       data_rdata_i,
    output logic              busy_o,
    output logic              load_valid_o,
    output logic [31:0]       load_data_o,
    output logic              load_err_o
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    size_t             size_q;
    logic              lu_q;
    logic [ADDR_W-1:0] addr_lo;
    logic [1:0]        off_q;
    logic              start, done, err_pulse;
    logic [31:0]       ext_lo, ext_hi, ext_res;
    logic              load_valid_q, load_err_q;
    logic [31:0]       load_data_q;

    assign off_q   = addr_q[1:0];
    assign addr_lo = {addr_q[ADDR_W-1:2], 2'b00};
    assign busy_o  = (state_q != IDLE);

`ifdef LOAD_ALIGNER_MISALIGNED_EN
    logic        capture_lo;
    logic [31:0] lo_buf;
    logic        mis_q;

    assign mis_q = is_misaligned(size_q, off_q);
`else
    logic mis_in;

    assign mis_in = is_misaligned(decode_size(lb_i, lh_i), addr_i[1:0]);
`endif

    always_comb begin
        state_d     = state_q;
        data_req_o  = 1'b0;
        data_addr_o = '0;
        data_be_o   = 4'b0000;
        start       = 1'b0;
        done        = 1'b0;
        err_pulse   = 1'b0;
`ifdef LOAD_ALIGNER_MISALIGNED_EN
        capture_lo  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (load_req_i) begin
`ifdef LOAD_ALIGNER_MISALIGNED_EN
                    start   = 1'b1;
                    state_d = REQ_LO;
`else
                    if (mis_in) begin
                        err_pulse = 1'b1;
                    end else begin
                        start   = 1'b1;
                        state_d = REQ_LO;
                    end
`endif
                end
            end
            REQ_LO: begin
                data_req_o  = 1'b1;
                data_addr_o = addr_lo;
                data_be_o   = be_lo(size_q, off_q);
                if (data_gnt_i)
                    state_d = WAIT_LO;
            end
            WAIT_LO: begin
                if (data_rvalid_i) begin
`ifdef LOAD_ALIGNER_MISALIGNED_EN
                    if (mis_q) begin
                        capture_lo = 1'b1;
                        state_d    = REQ_HI;
                    end else begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end
`else
                    done    = 1'b1;
                    state_d = IDLE;
`endif
                end
            end
`ifdef LOAD_ALIGNER_MISALIGNED_EN
            REQ_HI: begin
                data_req_o  = 1'b1;
                // Wraps modulo 2^ADDR_W at the top of the address space
                data_addr_o = addr_lo + {{(ADDR_W-3){1'b0}}, 3'b100};
                data_be_o   = be_hi(size_q, off_q);
                if (data_gnt_i)
                    state_d = WAIT_HI;
            end
            WAIT_HI: begin
                if (data_rvalid_i) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

`ifdef LOAD_ALIGNER_MISALIGNED_EN
    assign ext_lo = (state_q == WAIT_HI) ? lo_buf : data_rdata_i;
    assign ext_hi = (state_q == WAIT_HI) ? data_rdata_i : 32'd0;
`else
    assign ext_lo = data_rdata_i;
    assign ext_hi = 32'd0;
`endif

    load_extender u_ext (
        .lo     (ext_lo),
        .hi     (ext_hi),
        .off    (off_q),
        .size   (size_q),
        .lu     (lu_q),
        .result (ext_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            size_q  <= SZ_WORD;
            lu_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start) begin
                addr_q <= addr_i;
                size_q <= decode_size(lb_i, lh_i);
                lu_q   <= lu_i;
            end
        end
    end

`ifdef LOAD_ALIGNER_MISALIGNED_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lo_buf <= 32'd0;
        else if (capture_lo)
            lo_buf <= data_rdata_i;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_valid_q <= 1'b0;
            load_err_q   <= 1'b0;
            load_data_q  <= 32'd0;
        end else begin
            load_valid_q <= done | err_pulse;
            load_err_q   <= err_pulse;
            if (done)
                load_data_q <= ext_res;
            else if (err_pulse)
                load_data_q <= 32'd0;
        end
    end

    assign load_valid_o = load_valid_q;
    assign load_data_o  = load_data_q;
`ifdef LOAD_ALIGNER_MISALIGNED_EN
    assign load_err_o   = 1'b0;
`else
    assign load_err_o   = load_err_q;
`endif

endmodule

// File: tb/tb_load_aligner.sv
// Directed bench for load_aligner: vector table for single loads plus hand sequences for
// delayed grant, busy-time requests and mid-operation reset.
module tb_load_aligner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_req_i, lb_i, lh_i, lu_i;
    logic [31:0] addr_i;
    logic        data_req_o;
    logic [31:0] data_addr_o;
    logic [3:0]  data_be_o;
    logic        data_gnt_i, data_rvalid_i;
    logic [31:0] data_rdata_i;
    logic        busy_o, load_valid_o, load_err_o;
    logic [31:0] load_data_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    load_aligner #(.ADDR_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_req_i    (load_req_i),
        .lb_i          (lb_i),
        .lh_i          (lh_i),
        .lu_i          (lu_i),
        .addr_i        (addr_i),
        .data_req_o    (data_req_o),
        .data_addr_o   (data_addr_o),
        .data_be_o     (data_be_o),
        .data_gnt_i    (data_gnt_i),
        .data_rvalid_i (data_rvalid_i),
        .data_rdata_i  (data_rdata_i),
        .busy_o        (busy_o),
        .load_valid_o  (load_valid_o),
        .load_data_o   (load_data_o),
        .load_err_o    (load_err_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        lb, lh, lu;
        logic [31:0] addr;
        logic        mis;
        logic [31:0] rd_lo, rd_hi;
        logic [3:0]  be_lo, be_hi;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic apply(input vec_t v);
        logic [31:0] a_lo;
        a_lo = {v.addr[31:2], 2'b00};
        @(negedge clk);
        load_req_i = 1'b1; lb_i = v.lb; lh_i = v.lh; lu_i = v.lu; addr_i = v.addr;
        @(negedge clk);
        load_req_i = 1'b0;
        if (!v.mis) begin
            chk("req_lo", {31'd0, data_req_o}, 32'd1);
            chk("addr_lo", data_addr_o, a_lo);
            chk("be_lo", {28'd0, data_be_o}, {28'd0, v.be_lo});
            data_gnt_i = 1'b1;
            @(negedge clk);
            data_gnt_i = 1'b0;
            chk("early_valid", {31'd0, load_valid_o}, 32'd0);
            data_rvalid_i = 1'b1; data_rdata_i = v.rd_lo;
            @(negedge clk);
            data_rvalid_i = 1'b0;
            chk("valid", {31'd0, load_valid_o}, 32'd1);
            chk("data", load_data_o, v.exp);
            chk("err", {31'd0, load_err_o}, 32'd0);
            @(negedge clk);
            chk("pulse_end", {31'd0, load_valid_o}, 32'd0);
            chk("data_held", load_data_o, v.exp);
        end else begin
`ifdef LOAD_ALIGNER_MISALIGNED_EN
            chk("mis_req_lo", {31'd0, data_req_o}, 32'd1);
            chk("mis_addr_lo", data_addr_o, a_lo);
            chk("mis_be_lo", {28'd0, data_be_o}, {28'd0, v.be_lo});
            data_gnt_i = 1'b1;
            @(negedge clk);
            data_gnt_i = 1'b0;
            data_rvalid_i = 1'b1; data_rdata_i = v.rd_lo;
            @(negedge clk);
            data_rvalid_i = 1'b0;
            chk("mis_req_hi", {31'd0, data_req_o}, 32'd1);
            chk("mis_addr_hi", data_addr_o, a_lo + 32'd4);
            chk("mis_be_hi", {28'd0, data_be_o}, {28'd0, v.be_hi});
            data_gnt_i = 1'b1;
            @(negedge clk);
            data_gnt_i = 1'b0;
            chk("mis_early_valid", {31'd0, load_valid_o}, 32'd0);
            data_rvalid_i = 1'b1; data_rdata_i = v.rd_hi;
            @(negedge clk);
            data_rvalid_i = 1'b0;
            chk("mis_valid", {31'd0, load_valid_o}, 32'd1);
            chk("mis_data", load_data_o, v.exp);
            chk("mis_err", {31'd0, load_err_o}, 32'd0);
            @(negedge clk);
            chk("mis_pulse_end", {31'd0, load_valid_o}, 32'd0);
`else
            chk("err_no_req", {31'd0, data_req_o}, 32'd0);
            chk("err_busy", {31'd0, busy_o}, 32'd0);
            chk("err_valid", {31'd0, load_valid_o}, 32'd1);
            chk("err_flag", {31'd0, load_err_o}, 32'd1);
            chk("err_data", load_data_o, 32'd0);
            @(negedge clk);
            chk("err_pulse_end", {30'd0, load_valid_o, load_err_o}, 32'd0);
            chk("err_still_no_req", {31'd0, data_req_o}, 32'd0);
`endif
        end
    endtask

    initial begin
        //           lb    lh    lu    addr          mis   rd_lo         rd_hi         be_lo    be_hi    exp
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 32'hDEAD_BEEF, 32'h0,        4'b1111, 4'b0000, 32'hDEAD_BEEF};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0203, 1'b0, 32'h8000_0000, 32'h0,        4'b1000, 4'b0000, 32'hFFFF_FF80};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 32'h0000_0203, 1'b0, 32'h8000_0000, 32'h0,        4'b1000, 4'b0000, 32'h0000_0080};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0302, 1'b0, 32'h8001_0000, 32'h0,        4'b1100, 4'b0000, 32'hFFFF_8001};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 32'h0000_0302, 1'b0, 32'h8001_0000, 32'h0,        4'b1100, 4'b0000, 32'h0000_8001};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0201, 1'b0, 32'h0000_7F00, 32'h0,        4'b0010, 4'b0000, 32'h0000_007F};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0300, 1'b0, 32'h1234_F00D, 32'h0,        4'b0011, 4'b0000, 32'hFFFF_F00D};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0102_0304, 32'h0,        4'b1111, 4'b0000, 32'h0102_0304};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0601, 1'b0, 32'h00AB_CD00, 32'h0,        4'b0110, 4'b0000, 32'hFFFF_ABCD};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0401, 1'b1, 32'h4433_2211, 32'h8877_6655, 4'b1110, 4'b0001, 32'h5544_3322};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h0000_0403, 1'b1, 32'hAB00_0000, 32'h0000_00CD, 4'b1000, 4'b0001, 32'hFFFF_CDAB};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 32'hFFFF_FFFE, 1'b1, 32'h2222_1111, 32'h4444_3333, 4'b1100, 4'b0011, 32'h3333_2222};

        rst_n = 1'b0;
        load_req_i = 1'b0; lb_i = 1'b0; lh_i = 1'b0; lu_i = 1'b0; addr_i = 32'd0;
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = 32'd0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_req", {31'd0, data_req_o}, 32'd0);
        chk("rst_addr", data_addr_o, 32'd0);
        chk("rst_be", {28'd0, data_be_o}, 32'd0);
        chk("rst_flags", {29'd0, busy_o, load_valid_o, load_err_o}, 32'd0);
        chk("rst_data", load_data_o, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++)
            apply(vecs[i]);

        // Grant held off 3 cycles; stray rvalid and a second load request must be ignored
        @(negedge clk);
        load_req_i = 1'b1; lb_i = 1'b0; lh_i = 1'b0; lu_i = 1'b0; addr_i = 32'h0000_0500;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("hold_req", {31'd0, data_req_o}, 32'd1);
            chk("hold_addr", data_addr_o, 32'h0000_0500);
            chk("hold_be", {28'd0, data_be_o}, 32'h0000_000F);
            chk("hold_busy", {31'd0, busy_o}, 32'd1);
            load_req_i = 1'b1; addr_i = 32'h0000_0600;
            data_rvalid_i = 1'b1; data_rdata_i = 32'hBAD0_BAD0;
            @(negedge clk);
        end
        load_req_i = 1'b0;
        chk("hold_valid", {31'd0, load_valid_o}, 32'd0);
        data_gnt_i = 1'b1; data_rvalid_i = 1'b1;
        @(negedge clk);
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
        chk("wait_no_req", {31'd0, data_req_o}, 32'd0);
        chk("same_cycle_rvalid_dropped", {31'd0, load_valid_o}, 32'd0);
        @(negedge clk);
        chk("wait_busy", {31'd0, busy_o}, 32'd1);
        chk("wait_valid", {31'd0, load_valid_o}, 32'd0);
        data_rvalid_i = 1'b1; data_rdata_i = 32'hCAFE_F00D;
        @(negedge clk);
        data_rvalid_i = 1'b0;
        chk("delayed_valid", {31'd0, load_valid_o}, 32'd1);
        chk("delayed_data", load_data_o, 32'hCAFE_F00D);
        @(negedge clk);
        chk("not_queued_busy", {31'd0, busy_o}, 32'd0);
        chk("not_queued_req", {31'd0, data_req_o}, 32'd0);
        chk("not_queued_valid", {31'd0, load_valid_o}, 32'd0);

        // Reset in WAIT_LO aborts the load; the late rvalid must not produce a result
        load_req_i = 1'b1; addr_i = 32'h0000_0700;
        @(negedge clk);
        load_req_i = 1'b0; data_gnt_i = 1'b1;
        @(negedge clk);
        data_gnt_i = 1'b0;
        chk("pre_rst_busy", {31'd0, busy_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_flags", {29'd0, busy_o, load_valid_o, load_err_o}, 32'd0);
        chk("abort_req", {31'd0, data_req_o}, 32'd0);
        chk("abort_addr", data_addr_o, 32'd0);
        chk("abort_be", {28'd0, data_be_o}, 32'd0);
        chk("abort_data", load_data_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        data_rvalid_i = 1'b1; data_rdata_i = 32'h1111_1111;
        @(negedge clk);
        data_rvalid_i = 1'b0;
        chk("late_rvalid_busy", {31'd0, busy_o}, 32'd0);
        @(negedge clk);
        chk("late_rvalid_valid", {31'd0, load_valid_o}, 32'd0);
        chk("late_rvalid_data", load_data_o, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
